// File: rtl/coprocessor_pkg.sv
// Shared constants for the coprocessor instruction issue block:
// opcodes, FSM encoding, status layout and instruction field positions.
package coprocessor_pkg;

    localparam logic [3:0] OP_LOAD_A = 4'd0;
    localparam logic [3:0] OP_LOAD_B = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_SUB    = 4'd3;
    localparam logic [3:0] OP_MUL    = 4'd4;
    localparam logic [3:0] OP_TRANS  = 4'd5;
    localparam logic [3:0] OP_SCALE  = 4'd6;
    localparam logic [3:0] OP_CLEAR  = 4'd7;
    localparam logic [3:0] OP_DET    = 4'd8;
    localparam logic [3:0] OP_READ   = 4'd9;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ERROR    = 2;
    localparam int STAT_CODE_LSB = 3;
    localparam int STAT_SEQ_LSB  = 8;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_EXEC    = 2'd3;

    localparam int IW_GO       = 31;
    localparam int IW_OP_LSB   = 27;
    localparam int IW_OP_W     = 4;
    localparam int IW_SIZE_LSB = 25;
    localparam int IW_SIZE_W   = 2;
    localparam int IW_IDX_LSB  = 20;
    localparam int IW_IDX_W    = 5;
    localparam int IW_DATA_LSB = 12;
    localparam int IW_DATA_W   = 8;
    localparam int IW_RSVD_W   = 12;

    // Element count of an n x n matrix where n = size + 2.
    function automatic logic [5:0] elem_count(input logic [1:0] size);
        logic [5:0] dim;
        dim = 6'(size) + 6'd2;
        return dim * dim;
    endfunction

endpackage

// File: rtl/coprocessor_instr_decode.sv
// Legality check for a latched instruction: opcode range and,
// for element-addressed opcodes, index bounds against matrix size.
module coprocessor_instr_decode
    import coprocessor_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [1:0] size_i,
    input  logic [4:0] index_i,
    output logic       legal_o
);

    logic op_ok;
    logic uses_index;
    logic index_ok;

    assign op_ok      = (opcode_i <= OP_READ);
    assign uses_index = (opcode_i == OP_LOAD_A) || (opcode_i == OP_LOAD_B) ||
                        (opcode_i == OP_READ);
    assign index_ok   = ({1'b0, index_i} < elem_count(size_i));
    assign legal_o    = op_ok && (!uses_index || index_ok);

endmodule

// File: rtl/coprocessor_instruction_issue.sv
// Turns an HPS-written instruction word into one valid/ready command
// for the matrix unit, then tracks completion and publishes status.
module coprocessor_instruction_issue
    import coprocessor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SEQ_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_word,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [3:0]  cmd_opcode,
    output logic [1:0]  cmd_size,
    output logic [4:0]  cmd_index,
    output logic [7:0]  cmd_data,
    input  logic        exec_done,
    input  logic        exec_error,
    output logic [31:0] status_word
);

    localparam bit T_EN = (TIMEOUT_CYCLES > 0);
    localparam int TW   = T_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(T_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]       state_q, state_d;
    logic             go_q;
    logic             cmd_valid_q, cmd_valid_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       size_q, size_d;
    logic [4:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       code_q, code_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    logic go;
    logic go_edge;
    logic legal;
    logic timeout_hit;
    logic unused_rsvd;

    assign go          = instr_word[IW_GO];
    assign go_edge     = go && !go_q;
    assign timeout_hit = T_EN && (tcnt_q == T_LAST);
    assign unused_rsvd = ^instr_word[IW_RSVD_W-1:0];

    coprocessor_instr_decode u_dec (
        .opcode_i (op_q),
        .size_i   (size_q),
        .index_i  (idx_q),
        .legal_o  (legal)
    );

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        op_d        = op_q;
        size_d      = size_q;
        idx_d       = idx_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        code_d      = code_q;
        seq_d       = seq_q;
        tcnt_d      = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (go_edge) begin
                    op_d    = instr_word[IW_OP_LSB +: IW_OP_W];
                    size_d  = instr_word[IW_SIZE_LSB +: IW_SIZE_W];
                    idx_d   = instr_word[IW_IDX_LSB +: IW_IDX_W];
                    data_d  = instr_word[IW_DATA_LSB +: IW_DATA_W];
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    code_d  = ERR_NONE;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    cmd_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end else begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    code_d  = ERR_ILLEGAL;
                    state_d = S_ERR;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (state_q == S_WAIT) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                // Completion beats both a fresh accept and timeout expiry.
                if ((state_q == S_WAIT || cmd_ready) && exec_done) begin
                    cmd_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    if (exec_error) begin
                        error_d = 1'b1;
                        code_d  = ERR_EXEC;
                        state_d = S_ERR;
                    end else begin
                        done_d  = 1'b1;
                        seq_d   = seq_q + 1'b1;
                        state_d = S_DONE;
                    end
                end else if (state_q == S_ISSUE) begin
                    if (cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        tcnt_d      = '0;
                        state_d     = S_WAIT;
                    end
                end else if (timeout_hit) begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (!go) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            go_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            op_q        <= '0;
            size_q      <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= ERR_NONE;
            seq_q       <= '0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            go_q        <= go;
            cmd_valid_q <= cmd_valid_d;
            op_q        <= op_d;
            size_q      <= size_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            code_q      <= code_d;
            seq_q       <= seq_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_opcode = op_q;
    assign cmd_size   = size_q;
    assign cmd_index  = idx_q;
    assign cmd_data   = data_q;

    always_comb begin
        status_word                         = '0;
        status_word[STAT_BUSY]              = busy_q;
        status_word[STAT_DONE]              = done_q;
        status_word[STAT_ERROR]             = error_q;
        status_word[STAT_CODE_LSB +: 2]     = code_q;
        status_word[STAT_SEQ_LSB +: 8]      = 8'(seq_q);
    end

endmodule
